tacc_uni: RTL and testbench
===========================

Name: tacc_uni

Overview:
- Downstream consumer of a bank of temporal unipolar multipliers (tMUL stage) in the MAC16 datapath.
- Each lane delivers a product bitstream `iC` and a per-lane `iStop` flag.
- This block counts the 1s across all lanes over one multiply window.
- When every lane has stopped, it presents the binary dot-product sum through a valid/ready handshake to the next stage (requantiser / writeback).

Parameters:
- LANES, 16, number of multiplier lanes summed per cycle.
- ACCW, 16, accumulator and output width in bits; must be >= clog2(LANES*255+1).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous reset, active low.
- start  input  1  one-cycle pulse, issued in the same cycle as the multipliers' loadA; arms a new window.
- iC  input  LANES  per-lane product bit; already gated by that lane's stop.
- iStop  input  LANES  per-lane stop flag from the multipliers; 1 = lane idle or finished.
- oSum  output  ACCW  accumulated count of the last completed window.
- oValid  output  1  oSum holds a completed result.
- iReady  input  1  consumer accepts oSum when oValid && iReady.
- busy  output  1  window in progress (states ARM or RUN).

Behaviour:
- Reset (asynchronous, rst_n low): state = IDLE, accumulator = 0, oSum = 0, oValid = 0, busy = 0. Reset mid-window aborts the window; no partial result is ever emitted.
- FSM states are IDLE, ARM, RUN and DONE.
- IDLE:
  - On start, clear the accumulator to 0 and go to ARM.
  - Otherwise hold; oSum keeps its last value.
- ARM: exactly one cycle.
  - Covers the cycle after load, when the multipliers still report stop = 1.
  - iC and iStop are ignored; nothing is accumulated.
  - Always go to RUN.
- RUN, every cycle:
  - Accumulator += popcount(iC). The addition saturates at 2^ACCW-1 and never wraps.
  - Termination: if &iStop == 1 in this cycle, go to DONE. The same cycle's iC is still added, though it is 0 from correctly gated lanes.
  - Lanes loaded with operand 0 hold stop = 1 from the outset. If all lanes are zero, RUN lasts one cycle and the result is 0.
- DONE:
  - oValid = 1 and oSum = accumulator. oSum is registered and updated on the RUN->DONE edge.
  - oSum stays stable while oValid && !iReady.
  - When oValid && iReady, clear oValid on that edge and go to IDLE.
- busy = 1 in ARM and RUN, 0 otherwise.
- start is ignored in ARM, RUN and DONE, including the accept cycle in DONE. The controller must not issue start until busy = 0 and oValid = 0.
- Latency: a window with maximum operand N has its start in cycle 0, ARM in cycle 1, and RUN in cycles 2 .. N+2. oValid rises in cycle N+3.
- Changes to iC or iStop while in IDLE or DONE have no effect on any output.

Test Plan:
- Basic count: start; in RUN drive iC = 16'hFFFF, iStop = 0 for 3 cycles, then iStop = 16'hFFFF and iC = 0 -> oValid rises with oSum = 48, and busy = 0 at that point.
- Zero window: start; in RUN, iStop = 16'hFFFF on the first RUN cycle -> oSum = 0 and oValid one cycle later, i.e. 3 cycles after start.
- Backpressure: complete a window with oSum = 48 and hold iReady = 0 for 5 cycles -> oValid and oSum stay 48. Then iReady = 1 -> oValid = 0 next cycle, and a start pulsed in that accept cycle is ignored.
- Saturation: with ACCW = 4, start; drive iC = 16'h000F for 5 RUN cycles -> oSum = 15, not a wrapped value.
- Reset mid-RUN: start; after 2 RUN cycles with iC = 16'hFFFF, assert rst_n = 0 -> state IDLE, oSum = 0, oValid = 0, busy = 0 immediately. No oValid appears afterwards.
- Integration: 16 tMUL instances, all with iA = 4 and iB = 255, and sobolSeq = 0 -> oSum = 64.

Source files
------------

// File: rtl/tacc_uni.sv
// Temporal accumulator for unipolar tMUL lanes: counts product-stream 1s over one
// multiply window and hands the saturated binary sum downstream via valid/ready.
module tacc_uni #(
  parameter int LANES = 16,
  parameter int ACCW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LANES-1:0] iC,
  input  logic [LANES-1:0] iStop,
  output logic [ACCW-1:0]  oSum,
  output logic             oValid,
  input  logic             iReady,
  output logic             busy
);

  localparam int PCW  = $clog2(LANES + 1);
  localparam int SUMW = ((ACCW > PCW) ? ACCW : PCW) + 1;

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_e;

  state_e          state_q;
  logic [ACCW-1:0] acc_q;
  logic [ACCW-1:0] acc_d;
  logic [ACCW-1:0] sum_q;
  logic            valid_q;
  logic            busy_q;

  function automatic logic [PCW-1:0] popcount(input logic [LANES-1:0] v);
    logic [PCW-1:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) n = n + PCW'(v[i]);
    return n;
  endfunction

  // Sum is formed one bit wider than either operand so overflow is visible and clamps.
  function automatic logic [ACCW-1:0] sat_add(input logic [ACCW-1:0] a,
                                              input logic [PCW-1:0]  b);
    logic [SUMW-1:0] s;
    s = SUMW'(a) + SUMW'(b);
    if (|s[SUMW-1:ACCW]) return '1;
    return s[ACCW-1:0];
  endfunction

  assign acc_d = sat_add(acc_q, popcount(iC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      sum_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ARM;
          end
        end
        // Multipliers still report stop=1 right after load, so this cycle is skipped.
        ARM: state_q <= RUN;
        RUN: begin
          acc_q <= acc_d;
          if (&iStop) begin
            sum_q   <= acc_d;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (iReady) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oSum   = sum_q;
  assign oValid = valid_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_tacc_uni.sv
// Bench for tacc_uni: table-driven windows, hand sequences for corner cases and
// randomized lane windows against a lane-level reference model.
module tb_tacc_uni;

  logic        clk = 1'b0;
  logic        rst_n, start, iReady;
  logic [15:0] iC, iStop;
  logic [15:0] sum16;
  logic        v16, b16;
  logic [3:0]  sum4;
  logic        v4, b4;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  tacc_uni #(.LANES(16), .ACCW(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .iC(iC), .iStop(iStop),
    .oSum(sum16), .oValid(v16), .iReady(iReady), .busy(b16)
  );

  tacc_uni #(.LANES(16), .ACCW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .iC(iC), .iStop(iStop),
    .oSum(sum4), .oValid(v4), .iReady(iReady), .busy(b4)
  );

  typedef struct {
    logic [15:0] ic;
    int          runs;
    logic [15:0] fin_ic;
    int          exp16;
    int          exp4;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int total, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (total > mx) ? mx : total;
  endfunction

  // Start pulse, ARM with junk inputs, `runs` busy cycles, then an all-stop cycle.
  task automatic run_tbl(input vec_t v, input int idx);
    start = 1'b1; iC = 16'($urandom); iStop = 16'($urandom);
    step();
    start = 1'b0; iC = 16'($urandom); iStop = 16'($urandom);
    chk($sformatf("tbl%0d_busy_arm", idx), b16, 1);
    step();
    for (int k = 0; k < v.runs; k++) begin
      iC = v.ic; iStop = 16'h0000;
      step();
    end
    iC = v.fin_ic; iStop = 16'hFFFF;
    chk($sformatf("tbl%0d_valid_early", idx), v16, 0);
    step();
    chk($sformatf("tbl%0d_valid", idx), v16, 1);
    chk($sformatf("tbl%0d_sum16", idx), sum16, v.exp16);
    chk($sformatf("tbl%0d_sum4", idx), sum4, v.exp4);
    chk($sformatf("tbl%0d_busy_done", idx), b16, 0);
    iC = 16'($urandom); iStop = 16'($urandom); iReady = 1'b1;
    step();
    iReady = 1'b0;
    chk($sformatf("tbl%0d_accept", idx), v16, 0);
    iC = 16'($urandom); iStop = 16'($urandom);
    step();
    chk($sformatf("tbl%0d_hold_idle", idx), sum16, v.exp16);
  endtask

  // Lane model: lane l is active for n[l] RUN cycles and emits a product bit per
  // active cycle; the window ends on the first cycle in which no lane is active.
  task automatic run_rand(input bit allones, input int fixed_n, input int idx);
    int n[16];
    int mx;
    int total;
    int d;
    logic [15:0] ic, stp;
    mx = 0; total = 0;
    for (int l = 0; l < 16; l++) begin
      if (fixed_n >= 0) n[l] = fixed_n;
      else n[l] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12));
      if (n[l] > mx) mx = n[l];
    end
    start = 1'b1; iC = 16'($urandom); iStop = 16'($urandom);
    step();
    start = 1'b0; iC = 16'($urandom); iStop = 16'($urandom);
    step();
    for (int r = 0; r <= mx; r++) begin
      for (int l = 0; l < 16; l++) begin
        if (r < n[l]) begin
          stp[l] = 1'b0;
          ic[l]  = allones ? 1'b1 : 1'($urandom);
          total += int'(ic[l]);
        end else begin
          stp[l] = 1'b1;
          ic[l]  = 1'b0;
        end
      end
      iC = ic; iStop = stp;
      if (r == mx) chk($sformatf("rnd%0d_valid_early", idx), v16, 0);
      step();
    end
    chk($sformatf("rnd%0d_valid", idx), v16, 1);
    chk($sformatf("rnd%0d_sum16", idx), sum16, sat(total, 16));
    chk($sformatf("rnd%0d_sum4", idx), sum4, sat(total, 4));
    d = $urandom_range(0, 3);
    for (int k = 0; k < d; k++) begin
      iC = 16'($urandom); iStop = 16'($urandom);
      step();
      chk($sformatf("rnd%0d_hold", idx), {v16, sum16}, {1'b1, 16'(sat(total, 16))});
    end
    iReady = 1'b1;
    step();
    iReady = 1'b0;
    chk($sformatf("rnd%0d_accept", idx), v16, 0);
  endtask

  initial begin
    tbl[0] = '{16'hFFFF, 3,    16'h0000, 48,    15};
    tbl[1] = '{16'h0000, 0,    16'h0000, 0,     0};
    tbl[2] = '{16'h0001, 1,    16'h0000, 1,     1};
    tbl[3] = '{16'h0007, 4,    16'h0000, 12,    12};
    tbl[4] = '{16'h000F, 5,    16'h0000, 20,    15};
    tbl[5] = '{16'hAAAA, 5,    16'h0000, 40,    15};
    tbl[6] = '{16'h8001, 10,   16'h0000, 20,    15};
    tbl[7] = '{16'hFFFF, 2,    16'h0003, 34,    15};
    tbl[8] = '{16'hFFFF, 4096, 16'h0000, 65535, 15};

    rst_n = 1'b0; start = 1'b0; iC = '0; iStop = '0; iReady = 1'b0;
    #12;
    chk("reset_sum", sum16, 0);
    chk("reset_valid", v16, 0);
    chk("reset_busy", b16, 0);
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 9; i++) run_tbl(tbl[i], i);

    // Backpressure, then a start pulse in the accept cycle that must be ignored.
    start = 1'b1; step();
    start = 1'b0; step();
    for (int k = 0; k < 3; k++) begin
      iC = 16'hFFFF; iStop = 16'h0000; step();
    end
    iC = 16'h0000; iStop = 16'hFFFF; step();
    chk("bp_first_sum", sum16, 48);
    for (int k = 0; k < 5; k++) begin
      iC = 16'($urandom); iStop = 16'($urandom);
      step();
      chk("bp_hold", {v16, sum16}, {1'b1, 16'd48});
    end
    iReady = 1'b1; start = 1'b1;
    step();
    iReady = 1'b0; start = 1'b0;
    chk("bp_accept_valid", v16, 0);
    chk("bp_accept_busy", b16, 0);
    step();
    chk("bp_start_ignored", b16, 0);
    step();
    chk("bp_no_valid", v16, 0);

    run_rand(1'b1, 4, 100);
    chk("integ_sum", sum16, 64);

    // Reset in the middle of RUN aborts the window without any result.
    start = 1'b1; step();
    start = 1'b0; step();
    iC = 16'hFFFF; iStop = 16'h0000;
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_run_sum", sum16, 0);
    chk("rst_run_valid", v16, 0);
    chk("rst_run_busy", b16, 0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      iC = 16'($urandom); iStop = 16'($urandom);
      step();
      chk("rst_after_quiet", {v16, b16}, 2'b00);
    end

    for (int i = 0; i < 30; i++) run_rand(1'b0, -1, i);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
